mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 132 +++++++++++++
 tb/tb_mem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: wait-stated 256x8 memory slave with a four-phase Req/Ack
// handshake and a write-protected top region.
//
// Parameters
//   WAIT_CYCLES : wait states inserted before each access (0..15)
//   PROT_BASE   : lowest write-protected address; PROT_BASE..8'hFF reject writes
//
// Ports
//   MEM_clk    in   system clock, rising edge
//   MEM_rst_n  in   asynchronous active-low reset
//   Req        in   transaction request (held until Ack for a full handshake)
//   RAM_rw     in   1 = write, 0 = read
//   Addr       in   [7:0] access address
//   Data_in    in   [7:0] write data
//   Data_out   out  [7:0] registered read data, held until the next read
//   Ack        out  transaction complete
//   Busy       out  transaction in progress (WAIT, ACCESS, ACK)
//   Err        out  with Ack: write rejected by protection
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  PROT_BASE   = 8'hF0
) (
  input  logic       MEM_clk,
  input  logic       MEM_rst_n,
  input  logic       Req,
  input  logic       RAM_rw,
  input  logic [7:0] Addr,
  input  logic [7:0] Data_in,
  output logic [7:0] Data_out,
  output logic       Ack,
  output logic       Busy,
  output logic       Err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [7:0]  dout_q, dout_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        mem_we;

  // Storage has no reset: contents survive MEM_rst_n.
  logic [7:0]  mem_q [0:255];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    dout_d  = dout_q;
    ack_d   = ack_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // Only place a request is accepted; inputs are captured here and
        // ignored for the rest of the transaction.
        if (Req) begin
          addr_d  = Addr;
          wdata_d = Data_in;
          rw_d    = RAM_rw;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        state_d = ACK;
        ack_d   = 1'b1;
        err_d   = 1'b0;
        if (!rw_q)                  dout_d = mem_q[addr_q];
        else if (addr_q < PROT_BASE) mem_we = 1'b1;
        else                         err_d  = 1'b1;
      end
      ACK: begin
        // Hold Ack until the requester drops Req; if Req already fell
        // during the wait, this yields a single-cycle Ack pulse.
        if (!Req) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MEM_clk or negedge MEM_rst_n) begin
    if (!MEM_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // The write strobe is only raised from ACCESS, so a reset before that
  // edge leaves memory untouched.
  always_ff @(posedge MEM_clk) begin
    if (mem_we) mem_q[addr_q] <= wdata_q;
  end

  assign Data_out = dout_q;
  assign Ack      = ack_q;
  assign Err      = err_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int          W    = 2;
  localparam logic [7:0]  PROT = 8'hF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req, rw, req0, rw0;
  logic [7:0] addr, din, addr0, din0;
  logic [7:0] dout, dout0;
  logic       ack, busy, err, ack0, busy0, err0;

  mem_responder #(.WAIT_CYCLES(W), .PROT_BASE(PROT)) dut (
    .MEM_clk(clk), .MEM_rst_n(rst_n), .Req(req), .RAM_rw(rw), .Addr(addr),
    .Data_in(din), .Data_out(dout), .Ack(ack), .Busy(busy), .Err(err));

  mem_responder #(.WAIT_CYCLES(0), .PROT_BASE(PROT)) dut0 (
    .MEM_clk(clk), .MEM_rst_n(rst_n), .Req(req0), .RAM_rw(rw0), .Addr(addr0),
    .Data_in(din0), .Data_out(dout0), .Ack(ack0), .Busy(busy0), .Err(err0));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: what memory holds and what Data_out should show.
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_dout;

  // One full handshake on dut. Inputs are scrambled right after acceptance
  // so every transaction also exercises input latching.
  task automatic run_txn(input logic t_rw, input logic [7:0] t_a, input logic [7:0] t_d,
                         input int hold, output int lat, output logic busy_acc,
                         output logic err_o, output logic [7:0] dout_o,
                         output logic held_ok, output logic idle_ok);
    req = 1'b1; rw = t_rw; addr = t_a; din = t_d;
    @(posedge clk); #1;
    busy_acc = busy;
    rw = 1'($urandom); addr = 8'($urandom); din = 8'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; break; end
    end
    err_o = err; dout_o = dout;
    held_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!ack || err !== err_o) held_ok = 1'b0;
    end
    req = 1'b0;
    @(posedge clk); #1;
    idle_ok = !ack && !busy && !err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; din = '0;
    req0 = 1'b0; rw0 = 1'b0; addr0 = '0; din0 = '0;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (ack !== 1'b0)  begin n_fail++; $display("FAIL reset_ack: got %b exp 0", ack); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_chk++; if (err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b exp 0", err); end
    n_chk++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h exp 00", dout); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b exp 0", busy); end
    mdl_dout = 8'h00;
  endtask

  // Fill the writable region so every later read has a known answer.
  task automatic test_init();
    int lat; logic ba, e, h, io; logic [7:0] d, o;
    int bad = 0;
    for (int a = 0; a < int'(PROT); a++) begin
      d = 8'($urandom);
      run_txn(1'b1, 8'(a), d, 0, lat, ba, e, o, h, io);
      mdl_mem[a] = d;
      if (e !== 1'b0 || lat != W + 2 || o !== mdl_dout || !io) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL init_writes: got %0d bad exp 0", bad); end
  endtask

  task automatic test_basic();
    int lat; logic ba, e, h, io; logic [7:0] o;
    run_txn(1'b1, 8'h10, 8'h5A, 1, lat, ba, e, o, h, io);
    mdl_mem[8'h10] = 8'h5A;
    n_chk++; if (lat != W + 2) begin n_fail++; $display("FAIL wr_latency: got %0d exp %0d", lat, W + 2); end
    n_chk++; if (ba !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b exp 1", ba); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b exp 0", e); end
    n_chk++; if (o !== mdl_dout) begin n_fail++; $display("FAIL wr_dout_hold: got %h exp %h", o, mdl_dout); end
    n_chk++; if (!h || !io) begin n_fail++; $display("FAIL wr_handshake: held %b idle %b exp 1 1", h, io); end
    run_txn(1'b0, 8'h10, 8'h00, 0, lat, ba, e, o, h, io);
    mdl_dout = 8'h5A;
    n_chk++; if (lat != W + 2) begin n_fail++; $display("FAIL rd_latency: got %0d exp %0d", lat, W + 2); end
    n_chk++; if (o !== 8'h5A) begin n_fail++; $display("FAIL rd_data: got %h exp 5a", o); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b exp 0", e); end
  endtask

  task automatic test_protect();
    int lat; logic ba, e, h, io; logic [7:0] o, prior;
    // Protected contents are never written, so their value is whatever the
    // array powered up with; the first read establishes it.
    run_txn(1'b0, 8'hF0, 8'h00, 0, lat, ba, e, prior, h, io);
    mdl_mem[8'hF0] = prior; mdl_dout = prior;
    run_txn(1'b1, 8'hF0, 8'hAA, 2, lat, ba, e, o, h, io);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL prot_err: got %b exp 1", e); end
    n_chk++; if (lat != W + 2) begin n_fail++; $display("FAIL prot_latency: got %0d exp %0d", lat, W + 2); end
    n_chk++; if (!h) begin n_fail++; $display("FAIL prot_err_held: got %b exp 1", h); end
    n_chk++; if (!io) begin n_fail++; $display("FAIL prot_err_clear: got %b exp 1", io); end
    n_chk++; if (o !== mdl_dout) begin n_fail++; $display("FAIL prot_dout_hold: got %h exp %h", o, mdl_dout); end
    run_txn(1'b0, 8'hF0, 8'h00, 0, lat, ba, e, o, h, io);
    n_chk++; if (o !== mdl_mem[8'hF0]) begin n_fail++; $display("FAIL prot_readback: got %h exp %h", o, mdl_mem[8'hF0]); end
    // Boundary just below the protected region is writable.
    run_txn(1'b1, PROT - 8'd1, 8'h3C, 0, lat, ba, e, o, h, io);
    mdl_mem[PROT - 8'd1] = 8'h3C;
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL below_prot_err: got %b exp 0", e); end
    run_txn(1'b0, PROT - 8'd1, 8'h00, 0, lat, ba, e, o, h, io);
    mdl_dout = 8'h3C;
    n_chk++; if (o !== 8'h3C) begin n_fail++; $display("FAIL below_prot_rd: got %h exp 3c", o); end
  endtask

  task automatic test_addr_change();
    int lat; logic ba, e, h, io; logic [7:0] o;
    run_txn(1'b1, 8'h20, 8'hA5, 0, lat, ba, e, o, h, io);
    mdl_mem[8'h20] = 8'hA5;
    req = 1'b1; rw = 1'b0; addr = 8'h10; din = 8'h00;
    @(posedge clk); #1;
    addr = 8'h20; rw = 1'b1; din = 8'hFF;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; break; end
    end
    mdl_dout = mdl_mem[8'h10];
    n_chk++; if (lat != W + 2) begin n_fail++; $display("FAIL chg_latency: got %0d exp %0d", lat, W + 2); end
    n_chk++; if (dout !== mdl_dout) begin n_fail++; $display("FAIL chg_data: got %h exp %h", dout, mdl_dout); end
    req = 1'b0; rw = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b0, 8'h20, 8'h00, 0, lat, ba, e, o, h, io);
    mdl_dout = mdl_mem[8'h20];
    n_chk++; if (o !== 8'hA5) begin n_fail++; $display("FAIL chg_no_write: got %h exp a5", o); end
  endtask

  task automatic test_req_drop();
    int acks = 0;
    logic [7:0] a;
    a = 8'($urandom_range(0, int'(PROT) - 1));
    req = 1'b1; rw = 1'b0; addr = a;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    mdl_dout = mdl_mem[a];
    n_chk++; if (acks != 1) begin n_fail++; $display("FAIL drop_ack_pulse: got %0d cycles exp 1", acks); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b exp 0", busy); end
    n_chk++; if (dout !== mdl_dout) begin n_fail++; $display("FAIL drop_data: got %h exp %h", dout, mdl_dout); end
  endtask

  task automatic test_reset_abort();
    int lat; logic ba, e, h, io; logic [7:0] o;
    run_txn(1'b1, 8'h05, 8'hC3, 0, lat, ba, e, o, h, io);
    mdl_mem[8'h05] = 8'hC3;
    run_txn(1'b0, 8'h10, 8'h00, 0, lat, ba, e, o, h, io);
    mdl_dout = mdl_mem[8'h10];
    req = 1'b1; rw = 1'b1; addr = 8'h05; din = 8'h33;
    @(posedge clk); #1;
    @(posedge clk); #3;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    mdl_dout = 8'h00;
    n_chk++; if ({ack, busy, err} !== 3'b000 || dout !== 8'h00) begin
      n_fail++; $display("FAIL abort_outputs: got ack%b busy%b err%b dout%h exp all zero", ack, busy, err, dout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(1'b0, 8'h05, 8'h00, 0, lat, ba, e, o, h, io);
    mdl_dout = mdl_mem[8'h05];
    n_chk++; if (o !== 8'hC3) begin n_fail++; $display("FAIL abort_no_write: got %h exp c3", o); end
    n_chk++; if (lat != W + 2) begin n_fail++; $display("FAIL post_reset_latency: got %0d exp %0d", lat, W + 2); end
  endtask

  task automatic test_random();
    int lat; logic ba, e, h, io, t_rw, exp_err; logic [7:0] o, a, d;
    int bad_lat = 0, bad_err = 0, bad_dat = 0, bad_hs = 0;
    for (int n = 0; n < 80; n++) begin
      t_rw = 1'($urandom);
      a = t_rw ? 8'($urandom) : 8'($urandom_range(0, int'(PROT) - 1));
      d = 8'($urandom);
      run_txn(t_rw, a, d, int'($urandom_range(0, 2)), lat, ba, e, o, h, io);
      exp_err = t_rw && (a >= PROT);
      if (!t_rw)         mdl_dout = mdl_mem[a];
      else if (a < PROT) mdl_mem[a] = d;
      if (lat != W + 2) bad_lat++;
      if (e !== exp_err) bad_err++;
      if (o !== mdl_dout) bad_dat++;
      if (!h || !io || !ba) bad_hs++;
    end
    n_chk++; if (bad_lat != 0) begin n_fail++; $display("FAIL rand_latency: got %0d bad exp 0", bad_lat); end
    n_chk++; if (bad_err != 0) begin n_fail++; $display("FAIL rand_err: got %0d bad exp 0", bad_err); end
    n_chk++; if (bad_dat != 0) begin n_fail++; $display("FAIL rand_data: got %0d bad exp 0", bad_dat); end
    n_chk++; if (bad_hs != 0) begin n_fail++; $display("FAIL rand_handshake: got %0d bad exp 0", bad_hs); end
  endtask

  task automatic test_wait0();
    int lat;
    logic [7:0] got;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin rw0 = 1'b1; addr0 = 8'h30; din0 = 8'h77; end
        1: begin rw0 = 1'b0; addr0 = 8'h30; din0 = 8'h00; end
        default: begin rw0 = 1'b1; addr0 = 8'hFF; din0 = 8'h12; end
      endcase
      req0 = 1'b1;
      @(posedge clk); #1;
      addr0 = 8'($urandom);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk); #1;
        if (ack0) begin lat = i; break; end
      end
      n_chk++; if (lat != 2) begin n_fail++; $display("FAIL w0_latency%0d: got %0d exp 2", k, lat); end
      got = dout0;
      if (k == 1) begin
        n_chk++; if (got !== 8'h77) begin n_fail++; $display("FAIL w0_data: got %h exp 77", got); end
      end
      if (k == 2) begin
        n_chk++; if (err0 !== 1'b1 || got !== 8'h77) begin
          n_fail++; $display("FAIL w0_prot: got err%b dout%h exp err1 dout77", err0, got);
        end
      end
      req0 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_protect();
    test_addr_change();
    test_req_drop();
    test_reset_abort();
    test_random();
    test_wait0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
